// File: rtl/hilo_unit.sv
// HI/LO register pair for the MIPS core: captures multiply results, MTHI/MTLO
// writes, and runs an iterative restoring divider for DIV/DIVU.
module hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] alu_hi,
    input  logic [WIDTH-1:0] alu_lo,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             abort,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_MTHI = 3'b010;
    localparam logic [2:0] OP_MTLO = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_DIVU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [WIDTH-1:0]   hi_q, hi_n, lo_q, lo_n;
    logic [WIDTH-1:0]   rem_q, rem_n, quo_q, quo_n, dsr_q, dsr_n, dvd_q, dvd_n;
    logic               q_neg_q, q_neg_n, r_neg_q, r_neg_n, dz_q, dz_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               busy_q;

    logic               rs_neg, rt_neg;
    logic [WIDTH:0]     partial, diff;

    assign rs_neg = (op == OP_DIV) && rs_val[WIDTH-1];
    assign rt_neg = (op == OP_DIV) && rt_val[WIDTH-1];

    // Restoring step: shift in the next dividend bit, subtract when no borrow.
    assign partial = {rem_q, quo_q[WIDTH-1]};
    assign diff    = partial - {1'b0, dsr_q};

    always_comb begin
        state_n = state_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        rem_n   = rem_q;
        quo_n   = quo_q;
        dsr_n   = dsr_q;
        dvd_n   = dvd_q;
        q_neg_n = q_neg_q;
        r_neg_n = r_neg_q;
        dz_n    = dz_q;
        cnt_n   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid && !abort) begin
                    case (op)
                        OP_MULT: begin
                            hi_n = alu_hi;
                            lo_n = alu_lo;
                        end
                        OP_MTHI: hi_n = rs_val;
                        OP_MTLO: lo_n = rs_val;
                        OP_DIV, OP_DIVU: begin
                            dvd_n   = rs_val;
                            quo_n   = rs_neg ? (-rs_val) : rs_val;
                            dsr_n   = rt_neg ? (-rt_val) : rt_val;
                            rem_n   = '0;
                            q_neg_n = rs_neg ^ rt_neg;
                            r_neg_n = rs_neg;
                            dz_n    = (rt_val == '0);
                            cnt_n   = '0;
                            state_n = S_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            S_DIV: begin
                if (abort) begin
                    state_n = S_IDLE;
                end else begin
                    if (!diff[WIDTH]) begin
                        rem_n = diff[WIDTH-1:0];
                        quo_n = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_n = partial[WIDTH-1:0];
                        quo_n = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_n = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1))
                        state_n = S_FIX;
                end
            end
            S_FIX: begin
                state_n = S_IDLE;
                if (!abort) begin
                    if (dz_q) begin
                        lo_n = '1;
                        hi_n = dvd_q;
                    end else begin
                        lo_n = q_neg_q ? (-quo_q) : quo_q;
                        hi_n = r_neg_q ? (-rem_q) : rem_q;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dsr_q   <= '0;
            dvd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            rem_q   <= rem_n;
            quo_q   <= quo_n;
            dsr_q   <= dsr_n;
            dvd_q   <= dvd_n;
            q_neg_q <= q_neg_n;
            r_neg_q <= r_neg_n;
            dz_q    <= dz_n;
            cnt_q   <= cnt_n;
            busy_q  <= (state_n != S_IDLE);
        end
    end

    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: reference model feeds an expected queue
// of {HI,LO} pairs, compared once each operation has completed.
module tb_hilo_unit;

    logic        clk = 1'b0;
    logic        reset, op_valid, abort, busy;
    logic [2:0]  op;
    logic [31:0] alu_hi, alu_lo, rs_val, rt_val, hi_out, lo_out;
    logic [1:0]  state_dbg;

    logic [63:0] exp_q[$];
    logic [31:0] hi_m, lo_m;
    int          n_checks = 0;
    int          n_errors = 0;

    hilo_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .alu_hi(alu_hi), .alu_lo(alu_lo), .rs_val(rs_val), .rt_val(rt_val),
        .abort(abort), .hi_out(hi_out), .lo_out(lo_out), .busy(busy),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference results; SV signed / and % truncate toward zero as required.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, b,
                                          input logic [31:0] h, l);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (o)
            3'd1: return {a, b};
            3'd2: return {a, l};
            3'd3: return {h, a};
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            3'd5: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return {h, l};
        endcase
    endfunction

    // Called at a negedge; returns at a negedge with the op retired and checked.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a, b,
                          input bit disturb);
        logic [63:0] exp;
        int n;
        exp = model(o, a, b, hi_m, lo_m);
        {hi_m, lo_m} = exp;
        exp_q.push_back(exp);
        op_valid = 1'b1;
        op = o;
        rs_val = a;
        rt_val = b;
        alu_hi = a;
        alu_lo = b;
        #1;
        check({tag, "_no_fwd"}, hi_out, dut.hi_out);
        @(negedge clk);
        op_valid = 1'b0;
        op = 3'd0;
        if (o == 3'd4 || o == 3'd5) begin
            n = 0;
            while (busy && n < 100) begin
                n++;
                op_valid = 1'b0;
                if (disturb) begin
                    rs_val = $urandom;
                    rt_val = $urandom_range(1, 1000);
                    if (n == 5) begin
                        op_valid = 1'b1;
                        op = 3'd3;
                        rs_val = 32'd9;
                    end
                end
                @(negedge clk);
            end
            op_valid = 1'b0;
            op = 3'd0;
            check({tag, "_busy_cycles"}, 32'(n), 32'd33);
        end else begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        end
        exp = exp_q.pop_front();
        check({tag, "_hi"}, hi_out, exp[63:32]);
        check({tag, "_lo"}, lo_out, exp[31:0]);
    endtask

    initial begin
        logic [31:0] ra, rb;
        reset = 1'b1;
        op_valid = 1'b0;
        op = 3'd0;
        abort = 1'b0;
        alu_hi = '0;
        alu_lo = '0;
        rs_val = '0;
        rt_val = '0;
        hi_m = '0;
        lo_m = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        run_op("mult", 3'd1, 32'h0000_0001, 32'h8000_0000, 1'b0);
        run_op("mthi", 3'd2, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_op("mtlo", 3'd3, 32'h1234_5678, 32'd0, 1'b0);

        run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 1'b1);
        run_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op("div_min_m1", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_5_0", 3'd4, 32'd5, 32'd0, 1'b1);
        run_op("divu_5_0", 3'd5, 32'd5, 32'd0, 1'b0);
        run_op("div_m5_0", 3'd4, 32'hFFFF_FFFB, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 32'hFFFF);
            if (i % 2 == 1) rb = -rb;
            run_op("div_rand", (i < 3) ? 3'd4 : 3'd5, ra, rb, 1'b0);
        end

        // Abort in IDLE suppresses the same-cycle op.
        op_valid = 1'b1;
        op = 3'd2;
        rs_val = 32'h5555_5555;
        abort = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        abort = 1'b0;
        check("abort_idle_hi", hi_out, hi_m);

        run_op("pre_hi", 3'd2, 32'hA5A5_A5A5, 32'd0, 1'b0);
        run_op("pre_lo", 3'd3, 32'hA5A5_A5A5, 32'd0, 1'b0);
        op_valid = 1'b1;
        op = 3'd5;
        rs_val = 32'd100;
        rt_val = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        check("abort_busy_on", {31'd0, busy}, 32'd1);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi_out, 32'hA5A5_A5A5);
        check("abort_lo", lo_out, 32'hA5A5_A5A5);
        repeat (40) @(negedge clk);
        check("abort_hold_lo", lo_out, 32'hA5A5_A5A5);

        op_valid = 1'b1;
        op = 3'd5;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", hi_out, 32'd0);
        check("reset_lo", lo_out, 32'd0);

        run_op("post_rst_divu", 3'd5, 32'd100, 32'd7, 1'b0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
